// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone B4 pipelined slave-port monitor: tracks in-flight requests and
// flags protocol violations as sticky bits, one-cycle pulses and a maskable interrupt.
module wb_protocol_monitor #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned GRANULE         = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned CNT_WIDTH       = 16,
  localparam int unsigned SEL_WIDTH      = DATA_WIDTH / GRANULE,
  localparam int unsigned OutW           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  we_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  input  logic                  ack_o,
  input  logic                  err_o,
  input  logic                  stall_o,
  input  logic                  clr_i,
  input  logic [7:0]            irq_mask_i,
  output logic [7:0]            viol_o,
  output logic [7:0]            viol_pulse_o,
  output logic                  irq_o,
  output logic [OutW-1:0]       outstanding_o,
  output logic [CNT_WIDTH-1:0]  ack_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OutW-1:0] OutMax = OutW'(MAX_OUTSTANDING);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT_CYCLES);
  localparam logic [TmrW-1:0] TmrPre = TmrW'(TIMEOUT_CYCLES - 1);

  logic                  accept, resp, req_changed;
  logic [OutW-1:0]       outst_d, outst_q;
  logic [TmrW-1:0]       timer_d, timer_q;
  logic                  stalled_d, stalled_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  we_q;
  logic [7:0]            pulse_d, pulse_q, viol_d, viol_q;
  logic                  irq_d, irq_q;
  logic [CNT_WIDTH-1:0]  ack_cnt_d, ack_cnt_q, err_cnt_d, err_cnt_q;

  assign accept = cyc_i & stb_i & ~stall_o;
  assign resp   = cyc_i & (ack_o | err_o);

  // Compared against the request captured while the slave was stalling.
  assign req_changed = (adr_i != adr_q) | (we_i != we_q) | (sel_i != sel_q) |
                       (we_i & (dat_i != dat_q));

  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic inc, input logic clr);
    logic [CNT_WIDTH-1:0] base;
    base = clr ? '0 : cnt;
    if (inc && (base != '1)) begin
      base = base + 1'b1;
    end
    return base;
  endfunction

  always_comb begin
    outst_d = outst_q;
    if (!cyc_i) begin
      outst_d = '0;
    end else if (accept && !resp) begin
      if (outst_q != OutMax) outst_d = outst_q + 1'b1;
    end else if (resp && !accept) begin
      if (outst_q != '0) outst_d = outst_q - 1'b1;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (resp || (outst_q == '0)) begin
      timer_d = '0;
    end else if (timer_q != TmrMax) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    pulse_d    = '0;
    pulse_d[0] = ack_o & err_o;
    pulse_d[1] = resp & (outst_q == '0);
    pulse_d[2] = stb_i & ~cyc_i;
    pulse_d[3] = stalled_q & cyc_i & (~stb_i | req_changed);
    pulse_d[4] = accept & ~resp & (outst_q == OutMax);
    pulse_d[5] = ~resp & (outst_q != '0) & (timer_q == TmrPre);
    pulse_d[6] = ~cyc_i & (outst_q != '0);
    pulse_d[7] = (ack_o | err_o) & ~cyc_i;
  end

  // A violation in the clearing cycle survives the clear.
  assign viol_d    = (clr_i ? 8'h00 : viol_q) | pulse_d;
  assign irq_d     = |(viol_q & irq_mask_i);
  assign stalled_d = cyc_i & stb_i & stall_o;
  assign ack_cnt_d = cnt_next(ack_cnt_q, resp & ack_o, clr_i);
  assign err_cnt_d = cnt_next(err_cnt_q, resp & err_o, clr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q   <= '0;
      timer_q   <= '0;
      stalled_q <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      pulse_q   <= '0;
      viol_q    <= '0;
      irq_q     <= 1'b0;
      ack_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      outst_q   <= outst_d;
      timer_q   <= timer_d;
      stalled_q <= stalled_d;
      if (cyc_i && stb_i) begin
        adr_q <= adr_i;
        dat_q <= dat_i;
        sel_q <= sel_i;
        we_q  <= we_i;
      end
      pulse_q   <= pulse_d;
      viol_q    <= viol_d;
      irq_q     <= irq_d;
      ack_cnt_q <= ack_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign viol_o        = viol_q;
  assign viol_pulse_o  = pulse_q;
  assign irq_o         = irq_q;
  assign outstanding_o = outst_q;
  assign ack_cnt_o     = ack_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Bench for wb_protocol_monitor: directed scenarios then random traffic, every cycle
// compared against a transaction-level reference model.
module tb_wb_protocol_monitor;

  localparam int Max  = 4;
  localparam int To   = 16;
  localparam int CntW = 4;
  localparam int CMax = (1 << CntW) - 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic        ack = 1'b0, err = 1'b0, stall = 1'b0, clr = 1'b0;
  logic [7:0]  mask = '0;
  logic [7:0]  viol_o, viol_pulse_o;
  logic        irq_o;
  logic [2:0]  outstanding_o;
  logic [CntW-1:0] ack_cnt_o, err_cnt_o;

  int total = 0;
  int bad = 0;

  // Reference model state
  int         m_out, m_timer, m_ack, m_err, n_to;
  logic [7:0] m_viol, m_pulse;
  logic       m_irq, m_stalled, m_we;
  logic [15:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;

  wb_protocol_monitor #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .MAX_OUTSTANDING(Max),
    .TIMEOUT_CYCLES(To), .CNT_WIDTH(CntW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .adr_i(adr), .dat_i(dat), .sel_i(sel), .we_i(we),
    .stb_i(stb), .cyc_i(cyc), .ack_o(ack), .err_o(err), .stall_o(stall), .clr_i(clr),
    .irq_mask_i(mask), .viol_o(viol_o), .viol_pulse_o(viol_pulse_o), .irq_o(irq_o),
    .outstanding_o(outstanding_o), .ack_cnt_o(ack_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_timer = 0; m_ack = 0; m_err = 0;
    m_viol = '0; m_pulse = '0; m_irq = 1'b0; m_stalled = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},   32'(outstanding_o), 32'(m_out));
    chk({tag, ".viol"},  32'(viol_o),        32'(m_viol));
    chk({tag, ".pulse"}, 32'(viol_pulse_o),  32'(m_pulse));
    chk({tag, ".irq"},   32'(irq_o),         32'(m_irq));
    chk({tag, ".ack"},   32'(ack_cnt_o),     32'(m_ack));
    chk({tag, ".err"},   32'(err_cnt_o),     32'(m_err));
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [15:0] a,
                       input logic st, input logic ak, input logic er, input logic cl);
    cyc = c; stb = s; we = w; adr = a; stall = st; ack = ak; err = er; clr = cl;
  endtask

  // One clock: derive the expected outcome from the rules, then compare after the edge.
  task automatic step(input string tag);
    int acc, rsp, nout, ntim, nack, nerr;
    logic [7:0] p, nviol;
    logic nirq, chg;
    acc = (cyc && stb && !stall) ? 1 : 0;
    rsp = (cyc && (ack || err)) ? 1 : 0;
    chg = (adr != m_adr) || (we != m_we) || (sel != m_sel) || (we && dat != m_dat);
    p[0] = ack && err;
    p[1] = rsp == 1 && m_out == 0;
    p[2] = stb && !cyc;
    p[3] = m_stalled && cyc && (!stb || chg);
    p[4] = acc == 1 && rsp == 0 && m_out == Max;
    p[5] = rsp == 0 && m_out > 0 && m_timer == To - 1;
    p[6] = !cyc && m_out > 0;
    p[7] = (ack || err) && !cyc;
    nout = cyc ? m_out + acc - rsp : 0;
    if (nout > Max) nout = Max;
    if (nout < 0) nout = 0;
    ntim = (rsp == 1 || m_out == 0) ? 0 : ((m_timer < To) ? m_timer + 1 : To);
    nirq = |(m_viol & mask);
    nviol = (clr ? 8'h00 : m_viol) | p;
    nack = clr ? 0 : m_ack;
    nerr = clr ? 0 : m_err;
    if (rsp == 1 && ack && nack < CMax) nack++;
    if (rsp == 1 && err && nerr < CMax) nerr++;
    @(posedge clk_i);
    #1;
    m_out = nout; m_timer = ntim; m_irq = nirq; m_viol = nviol; m_pulse = p;
    m_ack = nack; m_err = nerr;
    m_stalled = cyc && stb && stall;
    if (cyc && stb) begin
      m_adr = adr; m_dat = dat; m_sel = sel; m_we = we;
    end
    if (p[5]) n_to++;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    n_to = 0;
    sel = 4'hf;
    dat = 32'h1234_5678;
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single write, acked two cycles later
    drive(1, 1, 1, 16'h0100, 0, 0, 0, 0); step("w1_acc");
    chk("w1_out1", 32'(outstanding_o), 32'd1);
    drive(1, 0, 1, 16'h0100, 0, 0, 0, 0); step("w1_wait");
    drive(1, 0, 1, 16'h0100, 0, 1, 0, 0); step("w1_ack");
    chk("w1_out0", 32'(outstanding_o), 32'd0);
    chk("w1_ackcnt", 32'(ack_cnt_o), 32'd1);
    chk("w1_viol", 32'(viol_o), 32'h00);

    // Overflow then timeout
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 16'(16'h0200 + 4 * i), 0, 0, 0, 0); step("ovf_acc");
    end
    chk("ovf_pulse", 32'(viol_pulse_o[4]), 32'd1);
    chk("ovf_out", 32'(outstanding_o), 32'd4);
    n_to = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 16'h0200, 0, 0, 0, 0); step("to_idle");
    end
    chk("to_once", 32'(n_to), 32'd1);
    chk("to_sticky", 32'(viol_o[5]), 32'd1);
    drive(0, 0, 0, 16'h0200, 0, 0, 0, 0); step("to_drop");

    // Stall hold violation, then simultaneous ack/err
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 1); step("sh_clr");
    drive(1, 1, 1, 16'h0010, 1, 0, 0, 0); step("sh_stall");
    drive(1, 1, 1, 16'h0014, 1, 0, 0, 0); step("sh_chg");
    chk("sh_viol", 32'(viol_o), 32'h08);
    drive(1, 1, 1, 16'h0014, 0, 0, 0, 0); step("sh_acc");
    drive(1, 0, 1, 16'h0014, 0, 1, 1, 0); step("sh_ackerr");
    chk("ae_viol", 32'(viol_o), 32'h09);
    chk("ae_ack", 32'(ack_cnt_o), 32'd1);
    chk("ae_err", 32'(err_cnt_o), 32'd1);

    // Response without cycle, orphan response, interrupt latency
    mask = 8'h80;
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 1); step("or_clr");
    drive(0, 0, 0, 16'h0000, 0, 1, 0, 0); step("or_nocyc");
    chk("or_v7", 32'(viol_o), 32'h80);
    chk("or_irq0", 32'(irq_o), 32'd0);
    drive(1, 0, 0, 16'h0000, 0, 1, 0, 0); step("or_orphan");
    chk("or_v1", 32'(viol_o), 32'h82);
    chk("or_irq1", 32'(irq_o), 32'd1);

    // Cycle dropped with requests in flight; clear racing a new violation
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 1); step("cd_clr");
    drive(1, 1, 0, 16'h0300, 0, 0, 0, 0); step("cd_acc1");
    drive(1, 1, 0, 16'h0304, 0, 0, 0, 0); step("cd_acc2");
    drive(0, 0, 0, 16'h0304, 0, 0, 0, 0); step("cd_drop");
    chk("cd_v6", 32'(viol_o[6]), 32'd1);
    chk("cd_out", 32'(outstanding_o), 32'd0);
    drive(0, 1, 0, 16'h0304, 0, 0, 0, 1); step("cd_clrstb");
    chk("cd_v04", 32'(viol_o), 32'h04);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 16'(16'h0400 + 4 * i), 0, 0, 0, 0); step("rs_acc");
    end
    chk("rs_out3", 32'(outstanding_o), 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("rs_async");
    @(negedge clk_i);
    drive(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    rst_ni = 1'b1;
    repeat (3) step("rs_idle");
    chk("rs_viol", 32'(viol_o), 32'h00);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc   = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 9) < 3);
      ack   = ($urandom_range(0, 9) < 3);
      err   = ($urandom_range(0, 99) < 8);
      clr   = ($urandom_range(0, 99) < 4);
      if (!(m_stalled && $urandom_range(0, 9) < 7)) begin
        stb = $urandom_range(0, 1) == 1;
        we  = $urandom_range(0, 1) == 1;
        adr = 16'($urandom_range(0, 3) * 4);
        sel = 4'($urandom_range(0, 15));
        dat = 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 19) == 0) mask = 8'($urandom_range(0, 255));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_protocol_monitor.md
Name: wb_protocol_monitor

Overview:
Synthesizable, parametrised Wishbone B4 pipelined-mode protocol monitor. Replaces the simulation-only assertion checker: it taps a slave port passively, tracks outstanding requests, detects protocol violations cycle by cycle, and reports them as sticky status, pulses and an interrupt. It sits beside each WB slave core and is usable in silicon or FPGA debug.

Parameters:
ADDR_WIDTH, 16, address bus width
DATA_WIDTH, 32, data bus width
GRANULE, 8, bits per select lane; SEL_WIDTH = DATA_WIDTH/GRANULE (localparam)
MAX_OUTSTANDING, 4, legal in-flight request limit (>=1)
TIMEOUT_CYCLES, 16, response-free cycles with requests pending before timeout (>=2)
CNT_WIDTH, 16, width of statistic counters

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
adr_i  in  ADDR_WIDTH  monitored address
dat_i  in  DATA_WIDTH  monitored write data
sel_i  in  SEL_WIDTH  monitored byte select
we_i  in  1  monitored write enable
stb_i  in  1  monitored strobe
cyc_i  in  1  monitored cycle
ack_o  in  1  monitored slave ack (slave output, monitor input)
err_o  in  1  monitored slave error
stall_o  in  1  monitored slave stall
clr_i  in  1  synchronous clear of sticky flags and counters
irq_mask_i  in  8  per-violation interrupt enable
viol_o  out  8  sticky violation flags
viol_pulse_o  out  8  one-cycle violation flags
irq_o  out  1  |(viol_o & irq_mask_i), registered
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  requests in flight
ack_cnt_o  out  CNT_WIDTH  saturating count of acks
err_cnt_o  out  CNT_WIDTH  saturating count of errs

Behaviour:
- Reset (rst_ni low, async): all outputs 0, outstanding 0, timer 0, stall-capture register invalid.
- accept = cyc_i & stb_i & !stall_o; resp = cyc_i & (ack_o | err_o).
- Outstanding: +1 on accept, -1 on resp, unchanged on both; saturates at MAX_OUTSTANDING and 0. Forced to 0 when cyc_i falls (abort).
- Violation bits (evaluated on sampled inputs; viol_pulse_o registered, visible one cycle after the offending edge):
  [0] ACK_ERR: ack_o & err_o.
  [1] ORPHAN: resp while outstanding==0 (minimum response latency is 1 cycle; same-cycle accept does not count).
  [2] STB_NO_CYC: stb_i & !cyc_i.
  [3] STALL_HOLD: previous cycle cyc&stb&stall_o, current cycle cyc_i high and either stb_i low or adr_i/we_i/sel_i changed, or dat_i changed when we_i=1.
  [4] OVERFLOW: accept while outstanding==MAX_OUTSTANDING and no resp same cycle; counter stays at max.
  [5] TIMEOUT: timer increments each cycle with outstanding>0 and no resp; clears on resp or outstanding==0; violation fires once when timer reaches TIMEOUT_CYCLES, then timer holds until cleared.
  [6] CYC_DROP: cyc_i falls while outstanding>0.
  [7] RESP_NO_CYC: (ack_o|err_o) & !cyc_i.
- viol_o bit set on pulse, held until clr_i. clr_i and new violation same cycle: bit ends set.
- ack_cnt_o/err_cnt_o increment on resp with ack_o/err_o respectively (both on ACK_ERR), saturate at all-ones, zeroed by clr_i; increment wins over clr_i in same cycle (count = 1).
- irq_o updates one cycle after viol_o changes.
- Monitor never drives the bus; no combinational path from inputs to outputs.

Test Plan:
- Single write, stall 0, ack 2 cycles later -> outstanding 1 then 0, ack_cnt_o=1, viol_o=0x00.
- 5 back-to-back accepts, MAX_OUTSTANDING=4, no acks -> viol_pulse_o[4] one cycle after 5th accept, outstanding_o stays 4; 16 idle cycles -> viol_o[5] set exactly once.
- Stalled request, adr_i changes 0x0010->0x0014 while stall_o=1 -> viol_o=0x08; ack_o&err_o together -> viol_o=0x09, ack_cnt_o=1, err_cnt_o=1.
- ack_o with cyc_i low -> viol_o[7]; ack_o with cyc_i high, nothing outstanding -> viol_o[1]; irq_mask_i=0x80 -> irq_o=1 only after the first.
- Two requests outstanding, cyc_i dropped -> viol_o[6], outstanding_o=0 next cycle; clr_i same cycle as stb_i&!cyc_i -> viol_o=0x04 after clear.
- rst_ni asserted mid-burst with outstanding 3 -> all outputs 0 immediately (asynchronous), no violation reported after release with idle bus.
